// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant per bus cycle, tenancy held while
// the owner keeps cyc high, with a no-ack watchdog that ends a stalled tenancy with err.
module wb_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [1:0]  m0_sel_i,
  output logic [15:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic [1:0]  m1_sel_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [15:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ERR} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] tmo, tmo_nxt;
  logic       err_pend, err_pend_nxt;
  logic       own_cyc, own_stb;

  // In GRANTn and ERR the owner is always the most recent winner.
  assign own_cyc = last ? m1_cyc_i : m0_cyc_i;
  assign own_stb = last ? m1_stb_i : m0_stb_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      last     <= 1'b1;
      tmo      <= 8'd0;
      err_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      tmo      <= tmo_nxt;
      err_pend <= err_pend_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    tmo_nxt      = tmo;
    err_pend_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        tmo_nxt = 8'd0;
        if (m0_cyc_i && (!m1_cyc_i || last)) begin
          state_nxt = GRANT0;
          last_nxt  = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt = GRANT1;
          last_nxt  = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        // The watchdog takes priority over a release in the same cycle.
        if (own_stb && !wb_ack_i) begin
          if (tmo == TMO_LAST) begin
            state_nxt    = ERR;
            err_pend_nxt = 1'b1;
            tmo_nxt      = 8'd0;
          end else begin
            tmo_nxt = tmo + 8'd1;
            if (!own_cyc) state_nxt = IDLE;
          end
        end else begin
          tmo_nxt = 8'd0;
          if (!own_cyc) state_nxt = IDLE;
        end
      end
      ERR: begin
        tmo_nxt = 8'd0;
        if (!own_cyc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wb_adr_o = 32'd0;
    wb_dat_o = 16'd0;
    wb_we_o  = 1'b0;
    wb_sel_o = 2'd0;
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    m0_dat_o = 16'd0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = 16'd0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    unique case (state)
      GRANT0: begin
        wb_adr_o = m0_adr_i;
        wb_sel_o = m0_sel_i;
        wb_cyc_o = m0_cyc_i;
        wb_stb_o = m0_stb_i;
        m0_ack_o = wb_ack_i;
        m0_dat_o = wb_dat_i;
      end
      GRANT1: begin
        wb_adr_o = m1_adr_i;
        wb_dat_o = m1_dat_i;
        wb_we_o  = m1_we_i;
        wb_sel_o = m1_sel_i;
        wb_cyc_o = m1_cyc_i;
        wb_stb_o = m1_stb_i;
        m1_ack_o = wb_ack_i;
        m1_dat_o = wb_dat_i;
      end
      ERR: begin
        m0_err_o = err_pend & ~last;
        m1_err_o = err_pend & last;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (TIMEOUT=8): reset, round-robin, long fill,
// write passthrough, watchdog error and late-ack cases.
module tb_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m0_adr_i, m1_adr_i;
  logic        m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [1:0]  m0_sel_i, m1_sel_i;
  logic [15:0] m1_dat_i, m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] wb_adr_o;
  logic [15:0] wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;
  logic [1:0]  wb_sel_o;

  typedef struct {logic n; logic [15:0] d;} exp_t;
  exp_t expQ[$];

  int checkCount = 0;
  int errorCount = 0;

  localparam logic [31:0] ADR0 = 32'h0000_0100;
  localparam logic [31:0] ADR1 = 32'h0000_0200;

  wb_arbiter #(.TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic n, input logic cyc, input logic stb);
    if (n) begin
      m1_cyc_i = cyc;
      m1_stb_i = stb;
    end else begin
      m0_cyc_i = cyc;
      m0_stb_i = stb;
    end
  endtask

  // Slave acks one beat; the expected return is queued and popped once the DUT shows it.
  task automatic beat(input logic n, input logic [15:0] d);
    exp_t e;
    wb_dat_i = d;
    wb_ack_i = 1'b1;
    expQ.push_back('{n, d});
    #1;
    e = expQ.pop_front();
    if (e.n) begin
      checkOutput("m1_ack", {31'd0, m1_ack_o}, 32'd1);
      checkOutput("m1_dat", {16'd0, m1_dat_o}, {16'd0, e.d});
      checkOutput("m0_ack_nonowner", {31'd0, m0_ack_o}, 32'd0);
    end else begin
      checkOutput("m0_ack", {31'd0, m0_ack_o}, 32'd1);
      checkOutput("m0_dat", {16'd0, m0_dat_o}, {16'd0, e.d});
      checkOutput("m1_ack_nonowner", {31'd0, m1_ack_o}, 32'd0);
    end
    tick();
    wb_ack_i = 1'b0;
    wb_dat_i = 16'd0;
  endtask

  task automatic checkOwner(input logic n);
    checkOutput("grant_cyc", {31'd0, wb_cyc_o}, 32'd1);
    checkOutput("grant_adr", wb_adr_o, n ? ADR1 : ADR0);
  endtask

  initial begin
    rst_i = 1'b1;
    m0_adr_i = ADR0; m1_adr_i = ADR1;
    m0_sel_i = 2'b11; m1_sel_i = 2'b11;
    m1_dat_i = 16'd0; m1_we_i = 1'b0;
    wb_dat_i = 16'd0; wb_ack_i = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);

    // Reset with both masters requesting
    tick();
    tick();
    checkOutput("rst_wb_cyc", {31'd0, wb_cyc_o}, 32'd0);
    checkOutput("rst_wb_stb", {31'd0, wb_stb_o}, 32'd0);
    checkOutput("rst_wb_adr", wb_adr_o, 32'd0);
    checkOutput("rst_acks", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
    checkOutput("rst_errs", {30'd0, m0_err_o, m1_err_o}, 32'd0);
    checkOutput("rst_dats", {m0_dat_o, m1_dat_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    checkOutput("post_rst_idle", {31'd0, wb_cyc_o}, 32'd0);
    tick();
    checkOwner(1'b0);

    // Round-robin through three tenancies with both cyc held
    for (int t = 0; t < 3; t++) begin
      for (int b = 0; b < 4; b++) beat(t[0], 16'(16'h1000 * (t + 1) + b));
      applyStimulus(t[0], 1'b0, 1'b0);
      #1;
      checkOutput("release_cyc", {31'd0, wb_cyc_o}, 32'd0);
      tick();
      checkOutput("idle_gap", {31'd0, wb_cyc_o}, 32'd0);
      if (t < 2) begin
        applyStimulus(t[0], 1'b1, 1'b1);
        tick();
        checkOwner(~t[0]);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();

    // Long icache fill; m1 waits without acks until m0 releases
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    checkOwner(1'b0);
    for (int b = 0; b < 48; b++) begin
      if (b == 5) applyStimulus(1'b1, 1'b1, 1'b1);
      beat(1'b0, 16'(16'h4000 + b));
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("fill_idle", {31'd0, wb_cyc_o}, 32'd0);
    tick();
    checkOwner(1'b1);

    // Write passthrough from m1
    m1_adr_i = 32'h0000_1002;
    m1_dat_i = 16'hBEEF;
    m1_sel_i = 2'b10;
    m1_we_i  = 1'b1;
    #1;
    checkOutput("wr_adr", wb_adr_o, 32'h0000_1002);
    checkOutput("wr_dat", {16'd0, wb_dat_o}, 32'h0000_BEEF);
    checkOutput("wr_sel", {30'd0, wb_sel_o}, 32'd2);
    checkOutput("wr_we", {31'd0, wb_we_o}, 32'd1);
    beat(1'b1, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0);
    m1_we_i  = 1'b0;
    m1_adr_i = ADR1;
    tick();

    // Watchdog: m1 stalls, err pulses 8 cycles after the first unacked stb
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) applyStimulus(1'b0, 1'b1, 1'b1);
      #1;
      checkOutput("tmo_wait_err", {31'd0, m1_err_o}, 32'd0);
      checkOutput("tmo_wait_cyc", {31'd0, wb_cyc_o}, 32'd1);
      tick();
    end
    checkOutput("tmo_err", {31'd0, m1_err_o}, 32'd1);
    checkOutput("tmo_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    checkOutput("tmo_no_ack", {31'd0, m1_ack_o}, 32'd0);
    tick();
    checkOutput("tmo_err_pulse", {31'd0, m1_err_o}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("tmo_idle", {31'd0, wb_cyc_o}, 32'd0);
    tick();
    checkOwner(1'b0);

    // Late ack on the 8th waiting cycle beats the watchdog
    for (int i = 0; i < 7; i++) begin
      checkOutput("late_wait_err", {31'd0, m0_err_o}, 32'd0);
      tick();
    end
    beat(1'b0, 16'hCAFE);
    checkOutput("late_no_err", {31'd0, m0_err_o}, 32'd0);
    checkOutput("late_cyc", {31'd0, wb_cyc_o}, 32'd1);
    beat(1'b0, 16'hF00D);

    // Reset in mid-tenancy
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("midrst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    checkOutput("midrst_err", {31'd0, m0_err_o}, 32'd0);
    tick();
    checkOwner(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
